// File: rtl/pci_target_pkg.sv
// Shared definitions for the PCI target data-phase controller:
// FSM state encoding, PCI memory command codes and the data bus width.
package pci_target_pkg;

    localparam int DATA_W = 32;

    localparam logic [3:0] CMD_MEM_RD = 4'b0110;
    localparam logic [3:0] CMD_MEM_WR = 4'b0111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_TURN = 2'd3
    } state_t;

    // True for the two commands this target claims; everything else is ignored.
    function automatic logic is_mem_cmd(input logic [3:0] cmd);
        return (cmd == CMD_MEM_RD) || (cmd == CMD_MEM_WR);
    endfunction

endpackage

// File: rtl/pci_target_regfile.sv
// DEPTH x DATA_W register file with per-byte write enables, one write port
// and one combinational read port. All words clear to zero on reset.
module pci_target_regfile
    import pci_target_pkg::*;
#(
    parameter int ADDR_W = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_W/8-1:0]   i_be,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [DATA_W-1:0]     o_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int LANES = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Storage array: async clear, then only the enabled byte lanes of the addressed word are updated.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            for (int b = 0; b < LANES; b++) begin
                if (i_be[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pci_target_data_phase.sv
// PCI target data-phase controller. Claims memory read/write cycles after the
// devSelect stage asserts devsel_n, drives trdy_n/stop_n and moves single or
// burst data to/from a small byte-enabled register file.
// Optional feature macro: TARGET_DISCONNECT_EN (disconnect-with-data at the
// top word of the register file instead of wrapping the burst address).
module pci_target_data_phase
    import pci_target_pkg::*;
#(
    parameter int ADDR_W  = 2,
    parameter int DSEL_TO = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_frame_n,
    input  logic              i_irdy_n,
    input  logic              i_devsel_n,
    input  logic [DATA_W-1:0] i_ad_in,
    input  logic [3:0]        i_cbe_n,
    output logic [DATA_W-1:0] o_ad_out,
    output logic              o_ad_oe,
    output logic              o_trdy_n,
    output logic              o_stop_n
);

    localparam int CNT_W = $clog2(DSEL_TO + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DSEL_TO - 1);
`ifdef TARGET_DISCONNECT_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
`endif

    state_t              r_state,    w_state_nxt;
    logic [ADDR_W-1:0]   r_addr,     w_addr_nxt;
    logic [3:0]          r_cmd,      w_cmd_nxt;
    logic [CNT_W-1:0]    r_cnt,      w_cnt_nxt;
    logic                r_bus_wait, w_bus_wait_nxt;
    logic                r_trdy_n,   w_trdy_n_nxt;
    logic                r_stop_n,   w_stop_n_nxt;
    logic                r_ad_oe,    w_ad_oe_nxt;
    logic [DATA_W-1:0]   r_ad_out,   w_ad_out_nxt;

    logic [ADDR_W-1:0]   w_addr_inc;
    logic [ADDR_W-1:0]   w_raddr;
    logic [DATA_W-1:0]   w_rdata;
    logic [3:0]          w_be;
    logic                w_we;
    logic                w_xfer;
    logic                w_last;

    // Burst address advances modulo DEPTH simply by letting the counter overflow.
    assign w_addr_inc = r_addr + ADDR_W'(1);
    assign w_xfer     = !i_irdy_n && !r_trdy_n;
    assign w_last     = i_frame_n;
    assign w_be       = ~i_cbe_n;
    // In the data phase the read port looks one word ahead so the next read word is ready on the transfer edge.
    assign w_raddr    = (r_state == S_DATA) ? w_addr_inc : r_addr;

    pci_target_regfile #(
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (w_we),
        .i_waddr (r_addr),
        .i_be    (w_be),
        .i_wdata (i_ad_in),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Next-state and next-output decode; every register holds its value unless a branch below changes it.
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_cmd_nxt      = r_cmd;
        w_cnt_nxt      = r_cnt;
        w_bus_wait_nxt = r_bus_wait;
        w_trdy_n_nxt   = r_trdy_n;
        w_stop_n_nxt   = r_stop_n;
        w_ad_oe_nxt    = r_ad_oe;
        w_ad_out_nxt   = r_ad_out;
        w_we           = 1'b0;

        case (r_state)
            S_IDLE: begin
                // After an unclaimed or abandoned cycle the bus must go fully idle before a new address phase counts.
                if (r_bus_wait) begin
                    if (i_frame_n && i_irdy_n) begin
                        w_bus_wait_nxt = 1'b0;
                    end
                end else if (!i_frame_n) begin
                    w_addr_nxt = i_ad_in[ADDR_W+1:2];
                    w_cmd_nxt  = i_cbe_n;
                    w_cnt_nxt  = '0;
                    if (is_mem_cmd(i_cbe_n)) begin
                        w_state_nxt = S_ADDR;
                    end else begin
                        w_bus_wait_nxt = 1'b1;
                    end
                end
            end

            S_ADDR: begin
                if (!i_devsel_n) begin
                    w_state_nxt  = S_DATA;
                    w_trdy_n_nxt = 1'b0;
                    if (r_cmd == CMD_MEM_RD) begin
                        w_ad_out_nxt = w_rdata;
                        w_ad_oe_nxt  = 1'b1;
                    end
`ifdef TARGET_DISCONNECT_EN
                    if (r_addr == LAST_ADDR) begin
                        w_stop_n_nxt = 1'b0;
                    end
`endif
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt    = S_IDLE;
                    w_bus_wait_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (i_devsel_n) begin
                    w_state_nxt    = S_IDLE;
                    w_trdy_n_nxt   = 1'b1;
                    w_stop_n_nxt   = 1'b1;
                    w_ad_oe_nxt    = 1'b0;
                    w_bus_wait_nxt = 1'b1;
                end else if (w_xfer) begin
                    w_we       = (r_cmd == CMD_MEM_WR);
                    w_addr_nxt = w_addr_inc;
                    if (w_last) begin
                        w_state_nxt  = S_TURN;
                        w_trdy_n_nxt = 1'b1;
                        w_ad_oe_nxt  = 1'b0;
                    end
`ifdef TARGET_DISCONNECT_EN
                    else if (!r_stop_n) begin
                        w_trdy_n_nxt = 1'b1;
                        w_ad_oe_nxt  = 1'b0;
                    end
`endif
                    else begin
                        if (r_cmd == CMD_MEM_RD) begin
                            w_ad_out_nxt = w_rdata;
                        end
`ifdef TARGET_DISCONNECT_EN
                        if (w_addr_inc == LAST_ADDR) begin
                            w_stop_n_nxt = 1'b0;
                        end
`endif
                    end
                end
`ifdef TARGET_DISCONNECT_EN
                else if (!r_stop_n && r_trdy_n && i_frame_n) begin
                    w_state_nxt = S_TURN;
                end
`endif
            end

            S_TURN: begin
                w_stop_n_nxt = 1'b1;
                w_state_nxt  = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered state and bus outputs, all forced idle by the async reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_cmd      <= '0;
            r_cnt      <= '0;
            r_bus_wait <= 1'b0;
            r_trdy_n   <= 1'b1;
            r_stop_n   <= 1'b1;
            r_ad_oe    <= 1'b0;
            r_ad_out   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_cmd      <= w_cmd_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bus_wait <= w_bus_wait_nxt;
            r_trdy_n   <= w_trdy_n_nxt;
            r_stop_n   <= w_stop_n_nxt;
            r_ad_oe    <= w_ad_oe_nxt;
            r_ad_out   <= w_ad_out_nxt;
        end
    end

    assign o_ad_out = r_ad_out;
    assign o_ad_oe  = r_ad_oe;
    assign o_trdy_n = r_trdy_n;
    assign o_stop_n = r_stop_n;

endmodule

// File: tb/tb_pci_target_data_phase.sv
// Bench for pci_target_data_phase: a PCI master model drives whole
// transactions while a word-array memory model predicts what the target must
// present on trdy_n/stop_n/ad_oe/ad_out after every clock.
module tb_pci_target_data_phase;
   import pci_target_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic        frameN = 1'b1;
   logic        irdyN = 1'b1;
   logic        devselN = 1'b1;
   logic [31:0] adIn = '0;
   logic [3:0]  cbeN = 4'hF;
   logic [31:0] adOut;
   logic        adOe;
   logic        trdyN;
   logic        stopN;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] refMem [DEPTH];
   logic        expTrdyN = 1'b1;
   logic        expStopN = 1'b1;
   logic        expAdOe = 1'b0;
   logic        expAdOutValid = 1'b1;
   logic [31:0] expAdOut = '0;

   logic [31:0] txData [16];
   logic [3:0]  txCbe [16];
   logic [31:0] capData [16];

   pci_target_data_phase dut (
      .i_clk      (clk),
      .i_rst_n    (rstN),
      .i_frame_n  (frameN),
      .i_irdy_n   (irdyN),
      .i_devsel_n (devselN),
      .i_ad_in    (adIn),
      .i_cbe_n    (cbeN),
      .o_ad_out   (adOut),
      .o_ad_oe    (adOe),
      .o_trdy_n   (trdyN),
      .o_stop_n   (stopN)
   );

   // Free-running PCI clock, period 10.
   always #5 clk = ~clk;

   // Safety net so the run can never hang.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Compare the DUT against the model on every falling edge, away from the active edge.
   always @(negedge clk) begin
      checkOutput("trdy_n", {31'b0, trdyN}, {31'b0, expTrdyN});
      checkOutput("stop_n", {31'b0, stopN}, {31'b0, expStopN});
      checkOutput("ad_oe", {31'b0, adOe}, {31'b0, expAdOe});
      if (expAdOutValid) checkOutput("ad_out", adOut, expAdOut);
   end

   // Drive one clock's worth of bus signals and advance to just past the next rising edge.
   task automatic applyStimulus(input logic f, input logic i, input logic d,
                                input logic [31:0] ad, input logic [3:0] cbe);
      frameN = f;
      irdyN = i;
      devselN = d;
      adIn = ad;
      cbeN = cbe;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] data,
                                              input logic [3:0] cbe);
      logic [31:0] r = old;
      for (int b = 0; b < 4; b++) if (!cbe[b]) r[8*b +: 8] = data[8*b +: 8];
      return r;
   endfunction

   // One complete master transaction; waitAt names the data phase preceded by waitLen wait states.
   task automatic doTxn(input bit isWrite, input int start, input int n, input int dselDly,
                        input int waitAt, input int waitLen);
      logic [31:0] aw;
      int a;
      aw = $urandom;
      aw[3:2] = start[1:0];
      applyStimulus(1'b0, 1'b1, 1'b1, aw, isWrite ? CMD_MEM_WR : CMD_MEM_RD);
      for (int i = 0; i < dselDly; i++)
         applyStimulus(logic'(n == 1), 1'b0, 1'b1, txData[0], txCbe[0]);
      applyStimulus(logic'(n == 1), 1'b0, 1'b0, txData[0], txCbe[0]);
      expTrdyN = 1'b0;
      expAdOe = !isWrite;
      if (!isWrite) begin
         expAdOut = refMem[start % DEPTH];
         expAdOutValid = 1'b1;
      end
      for (int k = 0; k < n; k++) begin
         a = (start + k) % DEPTH;
         if (k == waitAt)
            for (int w = 0; w < waitLen; w++)
               applyStimulus(logic'(k == n - 1), 1'b1, 1'b0, $urandom, 4'($urandom));
         capData[k] = adOut;
         applyStimulus(logic'(k == n - 1), 1'b0, 1'b0, txData[k], txCbe[k]);
         if (isWrite) refMem[a] = mergeBytes(refMem[a], txData[k], txCbe[k]);
         if (k == n - 1) begin
            expTrdyN = 1'b1;
            expAdOe = 1'b0;
            if (!isWrite) expAdOutValid = 1'b0;
         end else if (!isWrite) begin
            expAdOut = refMem[(a + 1) % DEPTH];
         end
      end
      applyStimulus(1'b1, 1'b1, 1'b1, $urandom, 4'hF);
      applyStimulus(1'b1, 1'b1, 1'b1, $urandom, 4'hF);
   endtask

   initial begin
      int nw;
      for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
      for (int i = 0; i < 16; i++) begin
         txData[i] = '0;
         txCbe[i] = 4'h0;
      end

      // Reset held for two clocks, outputs must sit at their idle values.
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h0, 4'hF);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h0, 4'hF);
      rstN = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h0, 4'hF);

      // Single write of a full word.
      txData[0] = 32'hDEADBEEF; txCbe[0] = 4'b0000;
      doTxn(1'b1, 1, 1, 0, 99, 0);
      checkOutput("t1 model mem1", refMem[1], 32'hDEADBEEF);

      // Byte-enabled write onto the same word.
      txData[0] = 32'h12345678; txCbe[0] = 4'b1100;
      doTxn(1'b1, 1, 1, 1, 99, 0);
      checkOutput("t2 model mem1", refMem[1], 32'hDEAD5678);

      // Fill remaining words, including a write burst that wraps 3 -> 0.
      txData[0] = 32'h33333333; txData[1] = 32'h00C0FFEE; txCbe[0] = 4'h0; txCbe[1] = 4'h0;
      doTxn(1'b1, 3, 2, 2, 99, 0);
      txData[0] = 32'h22222222;
      doTxn(1'b1, 2, 1, 0, 99, 0);

      // Four-word read burst from word 2, devsel on the last allowed clock.
      doTxn(1'b0, 2, 4, 3, 99, 0);
      checkOutput("t3 rd0", capData[0], 32'h22222222);
      checkOutput("t3 rd1", capData[1], 32'h33333333);
      checkOutput("t3 rd2", capData[2], 32'h00C0FFEE);
      checkOutput("t3 rd3", capData[3], 32'hDEAD5678);

      // Wait states in the middle of a write burst and of a read burst.
      txData[0] = 32'h0A0A0A0A; txData[1] = 32'h0B0B0B0B; txData[2] = 32'h0C0C0C0C;
      txCbe[0] = 4'h0; txCbe[1] = 4'h0; txCbe[2] = 4'h0;
      doTxn(1'b1, 0, 3, 0, 1, 3);
      doTxn(1'b0, 0, 4, 1, 2, 3);
      checkOutput("t4 rd0", capData[0], 32'h0A0A0A0A);
      checkOutput("t4 rd1", capData[1], 32'h0B0B0B0B);
      checkOutput("t4 rd2", capData[2], 32'h0C0C0C0C);
      checkOutput("t4 rd3", capData[3], 32'h33333333);

      // All byte enables off: no write, but the burst address still advances.
      txData[0] = 32'hFFFFFFFF; txCbe[0] = 4'b1111;
      txData[1] = 32'h11111111; txCbe[1] = 4'b0000;
      doTxn(1'b1, 0, 2, 0, 99, 0);
      doTxn(1'b0, 0, 2, 0, 99, 0);
      checkOutput("cbe1111 rd0", capData[0], 32'h0A0A0A0A);
      checkOutput("cbe1111 rd1", capData[1], 32'h11111111);

      // No devsel: four clocks of waiting, then a late devsel must be ignored.
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h0, CMD_MEM_RD);
      repeat (4) applyStimulus(1'b1, 1'b0, 1'b1, 32'h0, 4'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 4'h0);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h0, 4'hF);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h0, 4'hF);

      // I/O read is not claimed, even while the rest of its burst looks like a memory read.
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h0, 4'b0010);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, CMD_MEM_RD);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, CMD_MEM_RD);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h0, 4'hF);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h0, 4'hF);

      // Randomized traffic against the memory model.
      for (int t = 0; t < 40; t++) begin
         nw = $urandom_range(1, 6);
         for (int i = 0; i < nw; i++) begin
            txData[i] = $urandom;
            txCbe[i] = 4'($urandom_range(0, 15));
         end
         doTxn(1'($urandom_range(0, 1)), $urandom_range(0, 3), nw, $urandom_range(0, 3),
               ($urandom_range(0, 1) == 1) ? $urandom_range(0, nw - 1) : 99, $urandom_range(1, 3));
      end

      // Make sure the words read before reset are non-zero.
      txData[0] = 32'hA5A5A5A5; txData[1] = 32'h5A5A5A5A; txCbe[0] = 4'h0; txCbe[1] = 4'h0;
      doTxn(1'b1, 1, 2, 0, 99, 0);

      // Reset asserted in the middle of a read burst.
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h4, CMD_MEM_RD);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
      expTrdyN = 1'b0; expAdOe = 1'b1; expAdOut = refMem[1]; expAdOutValid = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
      expAdOut = refMem[2];
      @(negedge clk);
      #2;
      rstN = 1'b0;
      expTrdyN = 1'b1; expAdOe = 1'b0; expAdOut = '0; expAdOutValid = 1'b1; expStopN = 1'b1;
      for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
      #1;
      checkOutput("t6 async trdy_n", {31'b0, trdyN}, 32'd1);
      checkOutput("t6 async stop_n", {31'b0, stopN}, 32'd1);
      checkOutput("t6 async ad_oe", {31'b0, adOe}, 32'd0);
      checkOutput("t6 async ad_out", adOut, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h0, 4'hF);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h0, 4'hF);
      rstN = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h0, 4'hF);
      doTxn(1'b0, 0, 4, 0, 99, 0);
      for (int i = 0; i < 4; i++) checkOutput("t6 mem cleared", capData[i], 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
